// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed multiplier, radix-2 Booth recoding,
// one recoding step per clock, start/done handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only while busy=0
//   multiplicand signed operand M (N bits), captured on accepted start
//   multiplier   signed operand Q (N bits), captured on accepted start
//   busy         high while an operation is running
//   done         one-cycle pulse, product valid from this cycle
//   product      signed 2N-bit M*Q, held until the next result
//
// Optional build macro BOOTH_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits would only produce no-op recodings (variable latency).
module booth_mult_seq #(
  parameter int N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N:0]      a_q, mr_q;
  logic [N-1:0]    qr_q;
  logic            q1_q;
  logic [CW-1:0]   cnt_q;

  logic [N:0]      sum, a_sh;
  logic [N-1:0]    qr_sh;
  logic            q1_sh;
  logic            early;
  logic            last_step;

  // One Booth step: recode, add/sub, then arithmetic shift of {A,Qr,q_1}.
  always_comb begin
    sum = a_q;
    case ({qr_q[0], q1_q})
      2'b01:   sum = a_q + mr_q;
      2'b10:   sum = a_q - mr_q;
      default: sum = a_q;
    endcase
    a_sh  = {sum[N], sum[N:1]};
    qr_sh = {sum[0], qr_q[N-1:1]};
    q1_sh = qr_q[0];
  end

`ifdef BOOTH_EARLY_EXIT_EN
  logic [2*N-1:0] early_prod;

  // Remaining recodings are all 00/11 when every unprocessed Qr bit equals
  // q_1; the rest of the run then reduces to a plain arithmetic shift.
  always_comb begin
    early = (cnt_q != '0);
    for (int unsigned i = 0; i < N; i++) begin
      if ((i < 32'(cnt_q)) && (qr_q[i] != q1_q)) early = 1'b0;
    end
    early_prod = (2*N)'($signed({a_q, qr_q}) >>> cnt_q);
  end
`else
  assign early = 1'b0;
`endif

  assign last_step = (cnt_q == CW'(1)) || early;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      mr_q    <= '0;
      qr_q    <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      product <= '0;
    end else if (state_q != RUN) begin
      if (start) begin
        mr_q  <= {multiplicand[N-1], multiplicand};
        qr_q  <= multiplier;
        a_q   <= '0;
        q1_q  <= 1'b0;
        cnt_q <= CW'(N);
      end
    end else begin
      a_q   <= a_sh;
      qr_q  <= qr_sh;
      q1_q  <= q1_sh;
      cnt_q <= cnt_q - CW'(1);
`ifdef BOOTH_EARLY_EXIT_EN
      if (early) product <= early_prod;
      else if (last_step) product <= {a_sh[N-1:0], qr_sh};
`else
      if (last_step) product <= {a_sh[N-1:0], qr_sh};
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (N=5).
module tb_booth_mult_seq;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [4:0] m, q;
  logic       busy, done;
  logic [9:0] product;

  int checks = 0;
  int failures = 0;

`ifdef BOOTH_EARLY_EXIT_EN
  localparam int LAT_Q3  = 4;
  localparam int LAT_Q0  = 1;
  localparam int LAT_QM1 = 2;
  localparam int LAT_Q1  = 3;
`else
  localparam int LAT_Q3  = 5;
  localparam int LAT_Q0  = 5;
  localparam int LAT_QM1 = 5;
  localparam int LAT_Q1  = 5;
`endif

  booth_mult_seq #(.N(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(m), .multiplier(q),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one op from idle, wait (bounded) for done, check result/latency.
  task automatic run_op(input string tag, input logic [4:0] mm, input logic [4:0] qq,
                        input logic [9:0] exp, input int exp_lat);
    int lat, bc;
    start = 1'b1; m = mm; q = qq;
    step();
    start = 1'b0; m = 5'b0; q = 5'b0;
    lat = 0; bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      step();
      lat++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busycyc"}, 32'(bc), 32'(exp_lat));
    chk({tag, "_prod"}, 32'(product), 32'(exp));
    step();
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int lat, extra;
    rst = 1'b1; start = 1'b0; m = '0; q = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    rst = 1'b0;
    step();

    run_op("m3x5",    5'd3,     5'd5,     10'h00F, 5);
    run_op("mn7x3",   5'b11001, 5'd3,     10'h3EB, LAT_Q3);
    run_op("mn16xn16",5'b10000, 5'b10000, 10'h100, 5);
    run_op("m15xn16", 5'b01111, 5'b10000, 10'h310, 5);

    // start re-pulsed during a running op must be ignored
    start = 1'b1; m = 5'd3; q = 5'd5;
    step();
    m = 5'b11001; q = 5'd3;
    step(); step(); step();
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin step(); lat++; end
    chk("ign_lat", 32'(lat), 32'd5);
    chk("ign_prod", 32'(product), 32'h00F);
    extra = 0;
    for (int i = 0; i < 10; i++) begin step(); if (done) extra++; end
    chk("ign_extra_done", 32'(extra), 32'd0);

    // back-to-back: start held through DONE
    start = 1'b1; m = 5'b11001; q = 5'd3;
    step();
    lat = 0;
    while (!done && lat < 20) begin step(); lat++; end
    chk("b2b_lat1", 32'(lat), 32'(LAT_Q3));
    chk("b2b_prod1", 32'(product), 32'h3EB);
    m = 5'b01111; q = 5'b10000;
    step();
    start = 1'b0; m = '0; q = '0;
    chk("b2b_busy", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 20) begin step(); lat++; end
    chk("b2b_gap", 32'(lat), 32'd6);
    chk("b2b_prod2", 32'(product), 32'h310);
    step();

    // reset on RUN edge 3 discards the op
    start = 1'b1; m = 5'b10000; q = 5'b10000;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_prod", 32'(product), 32'd0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin step(); if (done) extra++; end
    chk("mid_rst_nodone", 32'(extra), 32'd0);

    // early-exit corner multipliers (fixed latency 5 without the macro)
    run_op("m9xq0",  5'd9, 5'd0,     10'h000, LAT_Q0);
    run_op("m9xqm1", 5'd9, 5'b11111, 10'h3F7, LAT_QM1);
    run_op("m9xq1",  5'd9, 5'd1,     10'h009, LAT_Q1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
